// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Wait-stated data-memory slave for a simple processor bus. One request is
//   accepted at a time and run through IDLE -> WAIT (WAIT_STATES cycles) ->
//   ACK. The block serves an internal RAM of MEM_DEPTH words and an LED output
//   register at IO_BASE. Bad accesses raise a sticky error flag.
//
// Ports
//   Clock        rising-edge clock
//   Reset        asynchronous, active-high reset
//   DataAddr     word address from the processor
//   DataOut      write data from the processor
//   ReadData     read request
//   WriteData    write request (wins if both are high)
//   DataIn       registered read data, valid in ACK and held until next read
//   DataWaitreq  combinational wait request
//   LEDR         registered memory-mapped output register
//   AccessErr    sticky error flag, cleared only by Reset
module data_mem_responder #(
    parameter int                   WORD_SIZE   = 16,
    parameter int                   MEM_DEPTH   = 256,
    parameter int                   WAIT_STATES = 2,
    parameter logic [WORD_SIZE-1:0] IO_BASE     = 'h1000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic [WORD_SIZE-1:0] LEDR,
    output logic                 AccessErr
);

    localparam int                 AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [WORD_SIZE:0] DEPTH_LIM = (WORD_SIZE+1)'(MEM_DEPTH);
    localparam logic [3:0]         WS_LOAD   = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 is_wr_q, is_wr_d;
    logic [WORD_SIZE-1:0] data_in_q, data_in_d;
    logic [WORD_SIZE-1:0] ledr_q, ledr_d;
    logic                 err_q, err_d;

    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    logic                 req;
    logic [WORD_SIZE-1:0] eff_addr;
    logic                 eff_io, eff_ram, new_bad;
    logic [WORD_SIZE-1:0] rd_val;
    logic                 mem_we;

    assign req = ReadData | WriteData;

    // With WAIT_STATES=0 the read data is captured on the accepting edge, so
    // decode the live bus address in IDLE and the latched one afterwards.
    assign eff_addr = (state_q == S_IDLE) ? DataAddr : addr_q;
    assign eff_io   = (eff_addr == IO_BASE);
    assign eff_ram  = !eff_io && ({1'b0, eff_addr} < DEPTH_LIM);
    assign new_bad  = (DataAddr != IO_BASE) && ({1'b0, DataAddr} >= DEPTH_LIM);

    // RAM index bits are only used once the range check has selected RAM.
    assign rd_val = eff_io  ? ledr_q :
                    eff_ram ? mem[eff_addr[AW-1:0]] : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        data_in_d = data_in_q;
        ledr_d    = ledr_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = DataAddr;
                    wdata_d = DataOut;
                    is_wr_d = WriteData;
                    if ((ReadData && WriteData) || new_bad) err_d = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                        if (!WriteData) data_in_d = rd_val;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    // Master gave up mid-access: drop it without side effects.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_ACK;
                    if (!is_wr_q) data_in_d = rd_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                // Write commits on the edge that ends ACK.
                state_d = S_IDLE;
                if (is_wr_q) begin
                    if (eff_io)       ledr_d = wdata_q;
                    else if (eff_ram) mem_we = !Reset;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            data_in_q <= '0;
            ledr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_wr_q   <= is_wr_d;
            data_in_q <= data_in_d;
            ledr_q    <= ledr_d;
            err_q     <= err_d;
        end
    end

    // RAM array has no reset; contents survive Reset.
    always_ff @(posedge Clock) begin
        if (mem_we) mem[addr_q[AW-1:0]] <= wdata_q;
    end

    assign DataWaitreq = !Reset && req && (state_q != S_ACK);
    assign DataIn      = data_in_q;
    assign LEDR        = ledr_q;
    assign AccessErr   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Three responders (WAIT_STATES 0, 2, 3) on one clock, each with its own
//   bus. A transaction-level model (word array, LED value, last read value,
//   sticky error) predicts DataIn, LEDR, AccessErr and the wait length.
module tb_data_mem_responder;

    localparam logic [15:0] IO = 16'h1000;

    logic        Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        rst  [3];
    logic        rd   [3];
    logic        wr   [3];
    logic [15:0] addr [3];
    logic [15:0] dout [3];
    logic [15:0] din  [3];
    logic [15:0] led  [3];
    logic        wrq  [3];
    logic        err  [3];

    data_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .Clock(Clock), .Reset(rst[0]), .DataAddr(addr[0]), .DataOut(dout[0]),
        .ReadData(rd[0]), .WriteData(wr[0]), .DataIn(din[0]),
        .DataWaitreq(wrq[0]), .LEDR(led[0]), .AccessErr(err[0]));
    data_mem_responder #(.WAIT_STATES(2)) u_ws2 (
        .Clock(Clock), .Reset(rst[1]), .DataAddr(addr[1]), .DataOut(dout[1]),
        .ReadData(rd[1]), .WriteData(wr[1]), .DataIn(din[1]),
        .DataWaitreq(wrq[1]), .LEDR(led[1]), .AccessErr(err[1]));
    data_mem_responder #(.WAIT_STATES(3)) u_ws3 (
        .Clock(Clock), .Reset(rst[2]), .DataAddr(addr[2]), .DataOut(dout[2]),
        .ReadData(rd[2]), .WriteData(wr[2]), .DataIn(din[2]),
        .DataWaitreq(wrq[2]), .LEDR(led[2]), .AccessErr(err[2]));

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_m [3][256];
    logic [15:0] led_m [3];
    logic [15:0] rdv_m [3];
    logic        err_m [3];

    function automatic int ws(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int d);
        led_m[d] = '0;
        rdv_m[d] = '0;
        err_m[d] = 1'b0;
    endtask

    // One complete access; leaves the request asserted during ACK so a
    // following call lands back-to-back.
    task automatic xact(input int d, input bit r, input bit w,
                        input logic [15:0] a, input logic [15:0] wd);
        int n;
        @(negedge Clock);
        addr[d] = a; dout[d] = wd; rd[d] = r; wr[d] = w;
        n = 0;
        #1;
        while (wrq[d] && n < 40) begin
            n++;
            @(negedge Clock);
            #1;
        end
        chk("waitreq_cycles", n, ws(d) + 1);
        if (r && w) err_m[d] = 1'b1;
        if (a != IO && a >= 16'd256) err_m[d] = 1'b1;
        if (r && !w)
            rdv_m[d] = (a == IO) ? led_m[d] : ((a < 16'd256) ? mem_m[d][a[7:0]] : 16'h0);
        chk("ack_data_in", din[d], rdv_m[d]);
        chk("ack_access_err", err[d], err_m[d]);
        chk("ack_ledr", led[d], led_m[d]);
        if (w) begin
            if (a == IO)            led_m[d] = wd;
            else if (a < 16'd256)   mem_m[d][a[7:0]] = wd;
        end
    endtask

    task automatic idle(input int d);
        @(negedge Clock);
        rd[d] = 1'b0; wr[d] = 1'b0;
        #1;
        chk("idle_waitreq", wrq[d], 0);
        chk("idle_ledr", led[d], led_m[d]);
        chk("idle_data_in", din[d], rdv_m[d]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, op;
        logic [15:0] a;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; dout[d] = '0;
            model_reset(d);
        end
        rd[0] = 1'b1;
        #2;
        chk("reset_waitreq_with_req", wrq[0], 0);
        for (int d = 0; d < 3; d++) begin
            chk("reset_data_in", din[d], 0);
            chk("reset_ledr", led[d], 0);
            chk("reset_access_err", err[d], 0);
        end
        @(negedge Clock);
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; rd[d] = 1'b0;
        end

        // Write/read through wait states.
        xact(1, 0, 1, 16'd5, 16'hBEEF);
        idle(1);
        xact(1, 1, 0, 16'd5, 16'h0);
        chk("read_beef", din[1], 16'hBEEF);
        idle(1);

        // LED register.
        xact(1, 0, 1, IO, 16'h00A5);
        idle(1);
        chk("ledr_a5", led[1], 16'h00A5);
        xact(1, 1, 0, IO, 16'h0);
        chk("read_io", din[1], 16'h00A5);
        idle(1);

        // Zero wait states, back-to-back.
        xact(0, 0, 1, 16'd0, 16'h0011);
        xact(0, 0, 1, 16'd1, 16'h0022);
        xact(0, 1, 0, 16'd0, 16'h0);
        chk("b2b_rd0", din[0], 16'h0011);
        xact(0, 1, 0, 16'd1, 16'h0);
        chk("b2b_rd1", din[0], 16'h0022);
        idle(0);

        // Out of range read: zero data, sticky error.
        xact(0, 1, 0, 16'h0300, 16'h0);
        chk("oob_data", din[0], 0);
        chk("oob_err", err[0], 1);
        idle(0);
        repeat (3) @(negedge Clock);
        chk("err_sticky", err[0], 1);
        xact(0, 1, 0, 16'd1, 16'h0);
        chk("err_sticky_after_ok", err[0], 1);
        idle(0);

        // Abort after two wait cycles on the 3-wait-state responder.
        xact(2, 0, 1, 16'd7, 16'h1234);
        idle(2);
        chk("pre_abort_err", err[2], 0);
        @(negedge Clock);
        addr[2] = 16'd7; dout[2] = 16'h5555; wr[2] = 1'b1;
        repeat (3) @(negedge Clock);
        #1;
        chk("abort_wait_held", wrq[2], 1);
        wr[2] = 1'b0; addr[2] = 16'd8;
        #1;
        chk("abort_waitreq", wrq[2], 0);
        @(negedge Clock);
        #1;
        err_m[2] = 1'b1;
        chk("abort_err", err[2], 1);
        chk("abort_data_in", din[2], rdv_m[2]);
        chk("abort_ledr", led[2], 0);
        xact(2, 1, 0, 16'd7, 16'h0);
        chk("abort_mem7", din[2], 16'h1234);
        idle(2);

        // Fill the 2-wait-state RAM so random reads are always defined.
        for (int i = 0; i < 256; i++) xact(1, 0, 1, 16'(i), 16'($urandom));
        idle(1);

        // Reset during the WAIT of a write.
        xact(1, 0, 1, 16'd9, 16'h0A0A);
        xact(1, 1, 0, 16'd9, 16'h0);
        idle(1);
        @(negedge Clock);
        addr[1] = 16'd9; dout[1] = 16'hFFFF; wr[1] = 1'b1;
        @(negedge Clock);
        #1;
        chk("rst_mid_waitreq_pre", wrq[1], 1);
        rst[1] = 1'b1;
        #1;
        chk("rst_mid_waitreq", wrq[1], 0);
        chk("rst_mid_data_in", din[1], 0);
        chk("rst_mid_ledr", led[1], 0);
        chk("rst_mid_err", err[1], 0);
        @(negedge Clock);
        rst[1] = 1'b0; wr[1] = 1'b0;
        model_reset(1);
        xact(1, 1, 0, 16'd9, 16'h0);
        chk("rst_mid_mem9", din[1], 16'h0A0A);
        idle(1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 70)      a = 16'($urandom_range(0, 255));
            else if (k < 85) a = IO;
            else             a = 16'($urandom_range(256, 65535));
            op = int'($urandom_range(0, 9));
            if (op == 0)     xact(1, 1, 1, a, 16'($urandom));
            else if (op < 5) xact(1, 0, 1, a, 16'($urandom));
            else             xact(1, 1, 0, a, 16'($urandom));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
